// File: rtl/product_reg_pkg.sv
// Shared constants and step-code decode for the shift-add product register.
package product_reg_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;
  localparam int CODE_W = 6;

  localparam logic [CODE_W-1:0] STEP_LOAD  = 6'd0;
  localparam logic [CODE_W-1:0] STEP_FIRST = 6'd1;
  localparam logic [CODE_W-1:0] STEP_MAX   = 6'd32;

  // Codes 1..32 are multiply steps; everything above is a hold code.
  function automatic logic is_step(input logic [CODE_W-1:0] code);
    return (code >= STEP_FIRST) && (code <= STEP_MAX);
  endfunction

endpackage

// File: rtl/product_shifter.sv
// Combinational next-state for one multiply step: optional add into the
// upper half, then a one-bit right shift across the 65-bit {carry, P} value.
// Bit 0 of P always falls off the end, so it is not brought in.
module product_shifter
  import product_reg_pkg::*;
(
  input  logic [PROD_W-1:1] p_src,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              adding,
  output logic [PROD_W-1:0] p_next
);

  // Add-then-shift takes the ALU sum plus carry as the new top 33 bits;
  // shift-only feeds a zero into the MSB.
  always_comb begin
    if (adding) begin
      p_next = {alu_carry, alu_result, p_src[DATA_W-1:1]};
    end else begin
      p_next = {1'b0, p_src[PROD_W-1:1]};
    end
  end

endmodule

// File: rtl/product_reg.sv
// Product register of a sequential shift-add multiplier: P = {hi, lo}.
// Optional macro PRODUCT_LSB_CHECK_EN adds a simulation-only check that the
// controller's sampled lsb matches P[0] on every step edge; the hardware is
// the same either way.
module product_reg
  import product_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [PROD_W-1:0] product_out,
  output logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic [DATA_W-1:0] multiplier_in,
  input  logic              adding_ctrl,
  input  logic [CODE_W-1:0] w_ctrl_Product,
  input  logic              lsb,
  input  logic              rdy
);

  logic [PROD_W-1:0] p;
  logic [PROD_W-1:0] p_next;
  logic [PROD_W-1:0] p_stepped;

  product_shifter u_shifter (
    .p_src      (p[PROD_W-1:1]),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .adding     (adding_ctrl),
    .p_next     (p_stepped)
  );

  // Select load, step or hold; rdy low freezes everything.
  always_comb begin
    p_next = p;
    if (rdy) begin
      if (w_ctrl_Product == STEP_LOAD) begin
        p_next = {{(PROD_W-DATA_W){1'b0}}, multiplier_in};
      end else if (is_step(w_ctrl_Product)) begin
        p_next = p_stepped;
      end
    end
  end

  // Product register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else begin
      p <= p_next;
    end
  end

  assign product_out = p;
  assign hi          = p[PROD_W-1:DATA_W];

`ifdef PRODUCT_LSB_CHECK_EN
  // The controller decides add vs. shift from lsb; flag it if it drifts from P[0].
  always @(posedge clk) begin
    if (!rst && rdy && is_step(w_ctrl_Product) && (lsb !== p[0])) begin
      $error("product_reg: lsb=%b disagrees with P[0]=%b at step %0d",
             lsb, p[0], w_ctrl_Product);
    end
  end
`else
  // lsb only feeds the optional check.
  logic unused_lsb;
  assign unused_lsb = lsb;
`endif

endmodule

// File: tb/tb_product_reg.sv
// Self-checking bench for product_reg: directed cases then randomized traffic
// compared against an arithmetic reference of the product register.
module tb_product_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] product_out;
  logic [31:0] hi;
  logic [31:0] alu_result = '0;
  logic        alu_carry = 1'b0;
  logic [31:0] multiplier_in = '0;
  logic        adding_ctrl = 1'b0;
  logic [5:0]  w_ctrl_Product = 6'd63;
  logic        lsb = 1'b0;
  logic        rdy = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [63:0] model = '0;

  always #5 clk = ~clk;

  product_reg dut (
    .clk            (clk),
    .rst            (rst),
    .product_out    (product_out),
    .hi             (hi),
    .alu_result     (alu_result),
    .alu_carry      (alu_carry),
    .multiplier_in  (multiplier_in),
    .adding_ctrl    (adding_ctrl),
    .w_ctrl_Product (w_ctrl_Product),
    .lsb            (lsb),
    .rdy            (rdy)
  );

  // Reference: integer view of the register. A step treats {carry, sum, lo}
  // as a 65-bit number and halves it; shift-only halves P.
  function automatic logic [63:0] ref_next(input logic [63:0] cur, input logic r,
                                           input logic [5:0] w, input logic add,
                                           input logic [31:0] res, input logic c,
                                           input logic [31:0] mplier);
    logic [64:0] wide;
    if (!r) return cur;
    if (w == 0) return {32'd0, mplier};
    if (w > 32) return cur;
    if (add) wide = {c, res, cur[31:0]};
    else     wide = {1'b0, cur};
    wide = wide / 2;
    return wide[63:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, settle 1 time unit.
  task automatic drive(input logic r, input logic [5:0] w, input logic add,
                       input logic [31:0] res, input logic c, input logic [31:0] mplier);
    @(negedge clk);
    rdy = r; w_ctrl_Product = w; adding_ctrl = add;
    alu_result = res; alu_carry = c; multiplier_in = mplier;
    lsb = model[0];
    @(posedge clk);
    model = ref_next(model, r, w, add, res, c, mplier);
    #1;
  endtask

  initial begin
    logic [63:0] held;
    // Reset state
    #12;
    check("reset_product", product_out, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load 50
    drive(1, 6'd0, 1, 32'hDEAD_BEEF, 1, 32'd50);
    check("load50", product_out, 64'h00000000_00000032);
    check("load50_hi", {32'd0, hi}, 64'd0);

    // Add step
    drive(1, 6'd1, 1, 32'd50, 0, 32'h1234);
    check("add_step", product_out, 64'h00000019_00000019);
    check("add_step_hi", {32'd0, hi}, 64'd25);

    // Shift-only step, with junk on ALU inputs
    drive(1, 6'd2, 0, 32'hFFFF_FFFF, 1, 32'h1234);
    check("shift_step", product_out, 64'h0000000C_8000000C);

    // Carry-in
    drive(1, 6'd0, 0, 32'h0, 0, 32'd1);
    drive(1, 6'd1, 1, 32'hFFFF_FFFF, 1, 32'd0);
    check("carry_in", product_out, 64'hFFFFFFFF_80000000);

    // Step code 32 is still a step (boundary)
    drive(1, 6'd32, 0, 32'h0, 0, 32'd0);
    check("step32", product_out, 64'h7FFFFFFF_C0000000);

    // Hold: rdy=0 with various codes, then rdy=1 w=40, and w=33 boundary
    held = product_out;
    drive(0, 6'd0, 1, 32'h5555_5555, 1, 32'd7);
    check("hold_rdy0_w0", product_out, held);
    drive(0, 6'd5, 1, 32'h5555_5555, 1, 32'd7);
    check("hold_rdy0_w5", product_out, held);
    drive(0, 6'd40, 0, 32'h5555_5555, 1, 32'd7);
    check("hold_rdy0_w40", product_out, held);
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'd40, 1, 32'hAAAA_AAAA, 1, 32'd9);
      check("hold_w40", product_out, held);
    end
    drive(1, 6'd33, 1, 32'hAAAA_AAAA, 1, 32'd9);
    check("hold_w33", product_out, held);
    drive(1, 6'd63, 0, 32'hAAAA_AAAA, 1, 32'd9);
    check("hold_w63", product_out, held);

    // Asynchronous reset between edges with P nonzero
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", product_out, 64'd0);
    check("async_reset_hi", {32'd0, hi}, 64'd0);
    // Reset wins over a load at the next edge
    rdy = 1; w_ctrl_Product = 6'd0; multiplier_in = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("reset_over_load", product_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model = '0;
    drive(1, 6'd0, 0, 32'h0, 0, 32'hCAFE_F00D);
    check("resume_load", product_out, 64'h00000000_CAFEF00D);

    // Randomized multiply-like traffic
    for (int n = 0; n < 300; n++) begin
      logic [5:0]  w;
      logic [31:0] mcand;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      w = 6'd0;
      else if (sel < 8)  w = 6'($urandom_range(1, 32));
      else               w = 6'($urandom_range(33, 63));
      mcand = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        logic [32:0] s;
        s = {1'b0, model[63:32]} + {1'b0, mcand};
        drive(($urandom_range(0, 4) != 0), w, model[0], s[31:0], s[32], $urandom);
      end else begin
        drive(($urandom_range(0, 4) != 0), w, 1'($urandom), $urandom, 1'($urandom), $urandom);
      end
      check("rand_product", product_out, model);
      check("rand_hi", {32'd0, hi}, {32'd0, model[63:32]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
